// File: rtl/sub_chunk_seq.sv
// sub_chunk_seq: multi-cycle subtractor that computes A - B one CHUNK-bit
// slice per clock, LSB slice first, with a valid/ready handshake on both sides.
// Build option: define SUB_CHUNK_SEQ_BORROW_EN to expose the final borrow-out
// on the Borrow port.
module sub_chunk_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sub
`ifdef SUB_CHUNK_SEQ_BORROW_EN
  ,
  output logic             Borrow
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sub_q, sub_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;

  logic [31:0]      shamt;
  logic [WIDTH-1:0] a_sh, b_sh, slice_mask, sub_ins;
  logic [CHUNK:0]   diff;

  // Slice datapath: pick operand slice k, subtract with borrow-in, merge
  // the CHUNK-bit result into the current Sub word at slice position k.
  // Shifts are used instead of variable part-selects so CHUNK == WIDTH works.
  always_comb begin
    shamt      = 32'(cnt_q) * 32'(CHUNK);
    a_sh       = a_q >> shamt;
    b_sh       = b_q >> shamt;
    diff       = {1'b0, a_sh[CHUNK-1:0]} - {1'b0, b_sh[CHUNK-1:0]}
               - {{CHUNK{1'b0}}, borrow_q};
    slice_mask = WIDTH'({CHUNK{1'b1}}) << shamt;
    sub_ins    = (sub_q & ~slice_mask) | (WIDTH'(diff[CHUNK-1:0]) << shamt);
  end

  // Control FSM: accept in IDLE, one slice per cycle in RUN, hold in DONE.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = A;
          b_d      = B;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        sub_d    = sub_ins;
        borrow_d = diff[CHUNK];
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Sub       = sub_q;

`ifdef SUB_CHUNK_SEQ_BORROW_EN
  // The borrow flop holds the last slice's borrow-out from DONE onward.
  assign Borrow = borrow_q;
`endif

endmodule

// File: tb/tb_sub_chunk_seq.sv
// Testbench for sub_chunk_seq: directed and randomized jobs checked against
// a plain arithmetic reference (A - B mod 2^WIDTH, borrow = A < B).
module tb_sub_chunk_seq;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sub;
`ifdef SUB_CHUNK_SEQ_BORROW_EN
  logic             Borrow;
`endif

  int checks = 0;
  int errors = 0;

  sub_chunk_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sub       (Sub)
`ifdef SUB_CHUNK_SEQ_BORROW_EN
    ,
    .Borrow    (Borrow)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model
  function automatic logic [WIDTH-1:0] ref_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return a - b;
  endfunction

  function automatic logic ref_borrow(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a < b);
  endfunction

  // One complete job. Called at a sample point with the DUT idle.
  // hold_mode=1 keeps in_valid high and moves A to a+2 during the job.
  task automatic run_job(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int stall, input bit hold_mode);
    logic [WIDTH-1:0] exp_s;
    int n;
    exp_s = ref_sub(a, b);
    A = a; B = b; in_valid = 1'b1; out_ready = 1'b0;
    chk("accept_ready", 64'(in_ready), 64'd1);
    tick();
    if (hold_mode) begin
      A = a + 2;
    end else begin
      in_valid = 1'b0;
      A = $urandom; B = $urandom;
    end
    n = 0;
    while (!out_valid && n < 20) begin
      chk("busy_ready", 64'(in_ready), 64'd0);
      tick();
      n++;
    end
    chk("latency", 64'(n), 64'(NCHUNK));
    chk("sub", 64'(Sub), 64'(exp_s));
`ifdef SUB_CHUNK_SEQ_BORROW_EN
    chk("borrow", 64'(Borrow), 64'(ref_borrow(a, b)));
`endif
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_sub", 64'(Sub), 64'(exp_s));
      chk("stall_ready", 64'(in_ready), 64'd0);
`ifdef SUB_CHUNK_SEQ_BORROW_EN
      chk("stall_borrow", 64'(Borrow), 64'(ref_borrow(a, b)));
`endif
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_ready", 64'(in_ready), 64'd1);
    chk("idle_sub", 64'(Sub), 64'(exp_s));
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic [WIDTH-1:0] exp_q[$];
    int cyc, last_acc, ndone, n;
    bit accepting;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    tick();
    tick();
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_sub", 64'(Sub), 64'd0);
`ifdef SUB_CHUNK_SEQ_BORROW_EN
    chk("rst_borrow", 64'(Borrow), 64'd0);
`endif
    rst = 1'b0;

    // Accept on the first edge after reset release
    run_job(32'd5, 32'd3, 0, 1'b0);
    // Borrow ripples through every slice
    run_job(32'd0, 32'd1, 2, 1'b0);
    // Long output stall
    run_job(32'h0001_0000, 32'h0000_0001, 10, 1'b0);
    // Inputs changing while busy are ignored
    run_job(32'd7, 32'd7, 1, 1'b1);

    // Reset in the middle of RUN
    A = 32'hFFFF_0000; B = 32'h0000_1234; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    chk("midrst_sub", 64'(Sub), 64'd0);
    tick();
    rst = 1'b0;
    chk("postrst_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("postrst_valid", 64'(out_valid), 64'd0);
    end
    run_job(32'd10, 32'd4, 0, 1'b0);

    // Randomized jobs
    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = (i % 3 == 0) ? ra : $urandom;
      run_job(ra, rb, int'($urandom_range(0, 3)), 1'b0);
    end

    // Back-to-back stream with both handshakes always asserted
    cyc = 0; last_acc = -1; ndone = 0;
    A = $urandom; B = $urandom; in_valid = 1'b1; out_ready = 1'b1;
    while (ndone < 5 && cyc < 200) begin
      if (out_valid) begin
        if (exp_q.size() > 0) begin
          chk("stream_sub", 64'(Sub), 64'(exp_q.pop_front()));
        end else begin
          chk("stream_extra_result", 64'd1, 64'd0);
        end
        ndone++;
      end
      accepting = in_ready && in_valid;
      if (accepting) begin
        if (last_acc >= 0) begin
          chk("stream_interval", 64'(cyc - last_acc), 64'(NCHUNK + 2));
        end
        last_acc = cyc;
        exp_q.push_back(ref_sub(A, B));
      end
      tick();
      cyc++;
      if (accepting) begin
        A = $urandom; B = $urandom;
      end
    end
    chk("stream_done", 64'(ndone), 64'd5);
    in_valid = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("stream_drain", 64'(in_ready), 64'd1);
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sub_chunk_seq.md
SUB_CHUNK_SEQ -- requirements
Module: sub_chunk_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, datapath slice width per cycle; WIDTH SHALL be an integer multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand pair offered.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port A  input  WIDTH  minuend.
REQ-008 SHALL have port B  input  WIDTH  subtrahend.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port Sub  output  WIDTH  A minus B, modulo 2^WIDTH.
REQ-012 SHALL have port Borrow  output  1  final borrow-out (A < B unsigned); present only per REQ-030.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-014 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 SHALL, in IDLE when in_valid=1, register A and B, clear the borrow flop and chunk counter to 0, and go to RUN.
REQ-016 SHALL, in RUN, each cycle compute one CHUNK-bit slice, LSB slice first: slice = A[k] - B[k] - borrow, write slice into Sub bits [k*CHUNK +: CHUNK], update borrow flop with slice borrow-out, increment counter k.
REQ-017 SHALL leave RUN for DONE on the cycle slice NCHUNK-1 is written; counter SHALL NOT wrap past NCHUNK-1.
REQ-018 SHALL assert out_valid exactly NCHUNK+1 rising edges after the accepting edge (accept edge -> NCHUNK RUN edges -> DONE visible).
REQ-019 SHALL hold Sub (and Borrow) stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-020 SHALL, in DONE with out_ready=1, return to IDLE on that edge; Sub SHALL retain its last value in IDLE.
REQ-021 SHALL ignore in_valid, A and B while in RUN or DONE; operands captured at accept SHALL be the only ones used.
REQ-022 SHALL support a new accept in the cycle after a DONE->IDLE transition (one idle bubble between jobs).
REQ-023 SHALL treat operands as unsigned for borrow; Sub is two's-complement wrap-around result independent of signedness.
REQ-024 SHALL, when CHUNK = WIDTH, complete in one RUN cycle (NCHUNK=1).

Reset
REQ-025 SHALL, on rst=1 at any time including mid-RUN or in DONE, immediately force state IDLE, abandoning the job without producing a result.
REQ-026 SHALL reset values: in_ready=1 after reset release, out_valid=0, Sub=0, Borrow=0, counter=0, borrow flop=0, operand registers=0.
REQ-027 SHALL accept a new operand pair on the first rising edge after rst deasserts if in_valid=1.

Configuration
REQ-028 SHALL use macro SUB_CHUNK_SEQ_BORROW_EN to control the Borrow port.
REQ-029 SHALL, without the macro, omit Borrow port and its output register; Sub behaviour unchanged.
REQ-030 SHALL, with the macro defined, expose Borrow = borrow flop value after slice NCHUNK-1, valid and held alongside Sub in DONE.

Verification
REQ-031 SHALL cover: A=5, B=3, WIDTH=32, CHUNK=8 -> out_valid 5 edges after accept, Sub=0x00000002, Borrow=0.
REQ-032 SHALL cover: A=0, B=1 -> Sub=0xFFFFFFFF, Borrow=1 (macro on); borrow ripples across all 4 slices.
REQ-033 SHALL cover: A=0x00010000, B=0x00000001 -> Sub=0x0000FFFF; out_ready held 0 for 10 cycles -> Sub, out_valid stable throughout.
REQ-034 SHALL cover: in_valid=1 with A=7, B=7 changing to A=9 during RUN -> result Sub=0, second pair not captured, in_ready=0 throughout RUN/DONE.
REQ-035 SHALL cover: rst pulsed at RUN slice 2 -> out_valid never asserts, in_ready=1 next cycle, next job A=10, B=4 -> Sub=6.
REQ-036 SHALL cover: back-to-back jobs with out_ready=1 and in_valid=1 continuous -> one accept every NCHUNK+2 cycles, results in order.
